// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types, response codes and the master FSM state encoding.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA
  } master_state_t;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle (AW/W/B/AR/R) with master and slave views; aclk comes from the system clock.
interface axi4l_if
  import axi4l_pkg::*;
(
  input logic aclk
);

  addr_t       awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  data_t       wdata;
  strb_t       wstrb;
  logic        wvalid;
  logic        wready;
  resp_t       bresp;
  logic        bvalid;
  logic        bready;
  addr_t       araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  data_t       rdata;
  resp_t       rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input aclk,
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/ibex_axi4l_master.sv
// Ibex req/gnt/rvalid memory port to AXI4-Lite master bridge, one transaction in flight.
module ibex_axi4l_master
  import axi4l_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req,
  output logic   gnt,
  input  logic   we,
  input  strb_t  be,
  input  addr_t  addr,
  input  data_t  wdata,
  output logic   rvalid,
  output data_t  rdata,
  output logic   err,
  axi4l_if.master axi
);

  master_state_t state_q, state_d;
  logic  awvalid_q, awvalid_d;
  logic  wvalid_q, wvalid_d;
  logic  arvalid_q, arvalid_d;
  logic  bready_q, bready_d;
  logic  rready_q, rready_d;
  logic  rvalid_q, rvalid_d;
  logic  err_q, err_d;
  data_t rdata_q, rdata_d;
  addr_t addr_q, addr_d;
  data_t wdata_q, wdata_d;
  strb_t wstrb_q, wstrb_d;

  assign gnt = req && (state_q == IDLE) && !reset;

  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.arprot  = 3'b000;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.arvalid = arvalid_q;
  assign axi.bready  = bready_q;
  assign axi.rready  = rready_q;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata;
          wstrb_d = be;
          if (we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR_DATA: begin
        // Each channel retires on its own handshake; move on once both are clear.
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          rvalid_d = 1'b1;
          err_d    = (axi.bresp != OKAY);
          rdata_d  = '0;
          state_d  = IDLE;
        end
      end
      RADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = axi.rdata;
          err_d    = (axi.rresp != OKAY);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
    // Request capture is only consumed behind a valid, so it needs no reset.
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

endmodule
